// File: rtl/ex_div_pkg.sv
// Shared types and sizing helpers for the execute-stage shared divider.
package ex_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  function automatic int lane_id_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider datapath: abs-value capture, one quotient bit per step, sign fix-up.
module div_iter_core
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             flush_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;

  logic [WIDTH:0]   shifted, diff, prem_nx;
  logic [WIDTH-1:0] quo_nx, q_fix, r_fix;
  logic             dvd_neg, dvs_neg;

  always_comb begin
    shifted = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    prem_nx = diff[WIDTH] ? shifted : diff;
    quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    q_fix   = qneg_q ? -quo_nx : quo_nx;
    r_fix   = rneg_q ? -prem_nx[WIDTH-1:0] : prem_nx[WIDTH-1:0];
    // Divide by zero bypasses the fix-up and reports the untouched dividend.
    quotient_o  = dvz_q ? '1 : q_fix;
    remainder_o = dvz_q ? orig_q : r_fix;
    last_o      = step_i && (cnt_q == CW'(1));
  end

  always_comb begin
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    orig_d  = orig_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dvz_d   = dvz_q;
    dvd_neg = signed_i & dividend_i[WIDTH-1];
    dvs_neg = signed_i & divisor_i[WIDTH-1];
    if (flush_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d  = CW'(WIDTH);
      prem_d = '0;
      quo_d  = dvd_neg ? -dividend_i : dividend_i;
      dvs_d  = dvs_neg ? -divisor_i : divisor_i;
      orig_d = dividend_i;
      qneg_d = dvd_neg ^ dvs_neg;
      rneg_d = dvd_neg;
      dvz_d  = (divisor_i == '0);
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d  = cnt_q - CW'(1);
      prem_d = prem_nx;
      quo_d  = quo_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prem_q <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      orig_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dvz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prem_q <= prem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      orig_q <= orig_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dvz_q  <= dvz_d;
    end
  end

endmodule

// File: rtl/ex_shared_div.sv
// Divider shared by all issue lanes: lowest-lane-first arbiter, IDLE/BUSY/DONE FSM, per-lane response.
// EX_SHARED_DIV_RESULT_CACHE_EN adds a one-entry result cache that answers repeated operands at T+1.
module ex_shared_div
  import ex_div_pkg::*;
#(
  parameter int LANES = 2,
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       req_valid_i,
  input  logic [LANES-1:0]       req_signed_i,
  input  logic [LANES*WIDTH-1:0] dividend_i,
  input  logic [LANES*WIDTH-1:0] divisor_i,
  output logic [LANES-1:0]       req_ready_o,
  output logic [LANES-1:0]       resp_valid_o,
  output logic [WIDTH-1:0]       quotient_o,
  output logic [WIDTH-1:0]       remainder_o,
  input  logic                   resp_ready_i,
  output logic                   busy_o,
  input  logic                   flush_i
);

  localparam int LW = lane_id_w(LANES);

  div_state_e       state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d, sel_lane;
  logic [LANES-1:0] resp_vld_q, resp_vld_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             accept, core_start, core_last;
  logic             sel_sgn;
  logic [WIDTH-1:0] sel_dvd, sel_dvs, core_quo, core_rem;
  logic             cache_hit;
  logic [WIDTH-1:0] hit_quo, hit_rem;

  always_comb begin
    sel_lane    = '0;
    req_ready_o = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (req_valid_i[k]) sel_lane = LW'(k);
    end
    if (state_q == ST_IDLE && !flush_i) req_ready_o = req_valid_i & (~req_valid_i + LANES'(1));
    accept  = |(req_valid_i & req_ready_o);
    sel_sgn = req_signed_i[sel_lane];
    sel_dvd = dividend_i[int'(sel_lane)*WIDTH +: WIDTH];
    sel_dvs = divisor_i[int'(sel_lane)*WIDTH +: WIDTH];
  end

  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (core_start),
    .step_i      (state_q == ST_BUSY),
    .flush_i     (flush_i),
    .signed_i    (sel_sgn),
    .dividend_i  (sel_dvd),
    .divisor_i   (sel_dvs),
    .last_o      (core_last),
    .quotient_o  (core_quo),
    .remainder_o (core_rem)
  );

`ifdef EX_SHARED_DIV_RESULT_CACHE_EN
  logic             c_vld_q, c_vld_d, c_sgn_q, c_sgn_d, op_sgn_q, op_sgn_d;
  logic [WIDTH-1:0] c_dvd_q, c_dvd_d, c_dvs_q, c_dvs_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
  logic [WIDTH-1:0] op_dvd_q, op_dvd_d, op_dvs_q, op_dvs_d;

  assign cache_hit = c_vld_q && (c_sgn_q == sel_sgn) && (c_dvd_q == sel_dvd) && (c_dvs_q == sel_dvs);
  assign hit_quo   = c_quo_q;
  assign hit_rem   = c_rem_q;

  // Only rst invalidates: a flushed op never completes, so it never writes.
  always_comb begin
    op_sgn_d = accept ? sel_sgn : op_sgn_q;
    op_dvd_d = accept ? sel_dvd : op_dvd_q;
    op_dvs_d = accept ? sel_dvs : op_dvs_q;
    c_vld_d  = c_vld_q;
    c_sgn_d  = c_sgn_q;
    c_dvd_d  = c_dvd_q;
    c_dvs_d  = c_dvs_q;
    c_quo_d  = c_quo_q;
    c_rem_d  = c_rem_q;
    if (state_q == ST_BUSY && core_last && !flush_i) begin
      c_vld_d = 1'b1;
      c_sgn_d = op_sgn_q;
      c_dvd_d = op_dvd_q;
      c_dvs_d = op_dvs_q;
      c_quo_d = core_quo;
      c_rem_d = core_rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld_q  <= 1'b0;
      c_sgn_q  <= 1'b0;
      c_dvd_q  <= '0;
      c_dvs_q  <= '0;
      c_quo_q  <= '0;
      c_rem_q  <= '0;
      op_sgn_q <= 1'b0;
      op_dvd_q <= '0;
      op_dvs_q <= '0;
    end else begin
      c_vld_q  <= c_vld_d;
      c_sgn_q  <= c_sgn_d;
      c_dvd_q  <= c_dvd_d;
      c_dvs_q  <= c_dvs_d;
      c_quo_q  <= c_quo_d;
      c_rem_q  <= c_rem_d;
      op_sgn_q <= op_sgn_d;
      op_dvd_q <= op_dvd_d;
      op_dvs_q <= op_dvs_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_quo   = '0;
  assign hit_rem   = '0;
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    resp_vld_d = resp_vld_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    core_start = 1'b0;
    if (flush_i) begin
      state_d    = ST_IDLE;
      resp_vld_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          lane_d = sel_lane;
          if (cache_hit) begin
            state_d    = ST_DONE;
            resp_vld_d = LANES'(1) << sel_lane;
            quo_d      = hit_quo;
            rem_d      = hit_rem;
          end else begin
            state_d    = ST_BUSY;
            core_start = 1'b1;
          end
        end
        ST_BUSY: if (core_last) begin
          state_d    = ST_DONE;
          resp_vld_d = LANES'(1) << lane_q;
          quo_d      = core_quo;
          rem_d      = core_rem;
        end
        ST_DONE: if (resp_ready_i) begin
          state_d    = ST_IDLE;
          resp_vld_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      resp_vld_q <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      resp_vld_q <= resp_vld_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign resp_valid_o = resp_vld_q & {LANES{~flush_i}};
  assign quotient_o   = quo_q;
  assign remainder_o  = rem_q;

endmodule

// File: tb/tb_ex_shared_div.sv
// Directed bench for ex_shared_div with hand-computed quotients, remainders and latencies.
module tb_ex_shared_div;

  localparam int W = 32;
  localparam int L = 2;
`ifdef EX_SHARED_DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 32;
`endif

  logic           clk, rst;
  logic [L-1:0]   req_valid, req_signed, req_ready, resp_valid;
  logic [L*W-1:0] dividend, divisor;
  logic [W-1:0]   quotient, remainder;
  logic           resp_ready, busy, flush;

  int n_chk = 0;
  int n_bad = 0;

  ex_shared_div #(.LANES(L), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_signed_i (req_signed),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .resp_ready_i (resp_ready),
    .busy_o       (busy),
    .flush_i      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_lane(input int lane, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[lane]           = 1'b1;
    req_signed[lane]          = sgn;
    dividend[lane*W +: W]     = a;
    divisor[lane*W +: W]      = b;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid == '0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Entered just after a rising edge with resp_ready=1; leaves the DUT idle.
  task automatic do_op(input string tag, input int lane, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int elat);
    int n;
    drive_lane(lane, sgn, a, b);
    n = 0;
    @(negedge clk);
    while (!req_ready[lane] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, req_ready, 2'(1) << lane);
    @(posedge clk);
    #1;
    req_valid[lane] = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    wait_resp(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_vld"}, resp_valid, 2'(1) << lane);
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    logic seen;
    rst        = 1'b1;
    req_valid  = '0;
    req_signed = '0;
    dividend   = '0;
    divisor    = '0;
    resp_ready = 1'b1;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_vld", resp_valid, 2'b00);
    chk("rst_quo", quotient, 32'h0);
    chk("rst_rem", remainder, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("u100_7", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    do_op("s_m7_2", 1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    do_op("dvz", 0, 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 32);
    do_op("ovf", 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32);

    // Both lanes request together; lane 1 must wait for lane 0's result to be consumed.
    resp_ready = 1'b0;
    drive_lane(0, 1'b0, 32'd100, 32'd7);
    drive_lane(1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    chk("arb_first", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("arb_busy_rdy", req_ready, 2'b00);
    wait_resp(n);
    chk("arb_l0_vld", resp_valid, 2'b01);
    chk("arb_l0_quo", quotient, 32'd14);
    @(negedge clk);
    chk("arb_hold_rdy", req_ready, 2'b00);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("arb_idle", busy, 1'b0);
    chk("arb_second", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    resp_ready   = 1'b1;
    wait_resp(n);
    chk("arb_l1_vld", resp_valid, 2'b10);
    chk("arb_l1_quo", quotient, 32'hFFFF_FFFD);
    chk("arb_l1_rem", remainder, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;

    // Flush in BUSY cycle 10.
    drive_lane(0, 1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("fl_busy", busy, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    drive_lane(1, 1'b0, 32'd5, 32'd1);
    chk("fl_vld", resp_valid, 2'b00);
    chk("fl_rdy", req_ready, 2'b00);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    req_valid[1] = 1'b0;
    chk("fl_idle", busy, 1'b0);
    req_valid[0] = 1'b1;
    flush        = 1'b1;
    #1;
    chk("fl_idle_rdy", req_ready, 2'b00);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    req_valid[0] = 1'b0;
    chk("fl_no_accept", busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | (|resp_valid);
    end
    chk("fl_no_resp", seen, 1'b0);
    do_op("f9_3", 0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 32);

    // Result cache: miss, hit, hit across flush, miss after reset.
    do_op("c1", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    do_op("c2", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, HIT_LAT);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_op("c3", 1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, HIT_LAT);
    drive_lane(0, 1'b0, 32'd77, 32'd5);
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_quo", quotient, 32'h0);
    chk("mid_rst_vld", resp_valid, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op("c4", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
